// File: rtl/eth10g_test_pkg.sv
// Shared definitions for the 10G SFP test path: frame length limits, the test
// EtherType, the generator state type and the byte-lane helpers used by both
// the frame generator and the receive checker.
package eth10g_test_pkg;

  localparam int unsigned ETH_MIN_LEN   = 60;
  localparam int unsigned ETH_MAX_LEN   = 1514;
  localparam logic [15:0] ETH_TYPE_TEST = 16'h88B5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    IFG  = 2'd2
  } gen_state_t;

  // Frame length without FCS, forced into the legal Ethernet range.
  function automatic logic [10:0] clamp_len(input logic [10:0] len);
    if (len < 11'(ETH_MIN_LEN)) return 11'(ETH_MIN_LEN);
    if (len > 11'(ETH_MAX_LEN)) return 11'(ETH_MAX_LEN);
    return len;
  endfunction

  // Byte idx of a test frame: 18-byte header (dst, src, type, seq; all MSB
  // first) followed by a ramp whose value is the low byte of its index.
  function automatic logic [7:0] frame_byte(
    input logic [10:0] idx,
    input logic [47:0] dst,
    input logic [47:0] src,
    input logic [15:0] etype,
    input logic [31:0] seq
  );
    logic [143:0] w_hdr;
    if (idx < 11'd18) begin
      w_hdr = {dst, src, etype, seq} << {idx[4:0], 3'b000};
      return w_hdr[143:136];
    end
    return idx[7:0];
  endfunction

endpackage

// File: rtl/eth10g_frame_gen.sv
// Test-traffic source for the 10G MAC transmit interface. Emits numbered
// Ethernet frames (no FCS) on a 64-bit AXI4-Stream master while enabled.
// Ports:
//   sysclk_100m, sys_reset_n     clock, synchronous active-low reset
//   enable                       start frames (sampled in IDLE only)
//   frame_len, dst_mac, src_mac  frame parameters, latched at frame start
//   m_axis_t*                    AXI4-Stream master (byte n in lane n%8)
//   frame_count                  frames fully transferred since reset
//   busy                         high while sending or in the inter-frame gap
module eth10g_frame_gen
  import eth10g_test_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = 2,
  parameter logic [15:0] ETH_TYPE   = ETH_TYPE_TEST
) (
  input  logic        sysclk_100m,
  input  logic        sys_reset_n,
  input  logic        enable,
  input  logic [10:0] frame_len,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [31:0] frame_count,
  output logic        busy
);

  // Gap counter terminal value; unused when IFG_CYCLES is 0.
  localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);

  gen_state_t  r_state;
  gen_state_t  w_next;
  logic [7:0]  r_beat;
  logic [7:0]  r_last_beat;
  logic [7:0]  r_ifg_cnt;
  logic [10:0] r_len;
  logic [47:0] r_dst;
  logic [47:0] r_src;
  logic [31:0] r_seq;
  logic [31:0] r_frame_count;
  logic        r_busy;

  logic        w_start;
  logic        w_hs;
  logic        w_last_hs;
  logic [10:0] w_len;
  logic        w_tvalid;
  logic        w_tlast;
  logic [63:0] w_tdata;
  logic [7:0]  w_tkeep;

  assign w_len     = clamp_len(frame_len);
  assign w_start   = (r_state == IDLE) && enable;
  assign w_hs      = w_tvalid && m_axis_tready;
  assign w_last_hs = w_hs && (r_beat == r_last_beat);

  // State register; busy is registered from the next state so it tracks
  // the state exactly.
  always_ff @(posedge sysclk_100m) begin
    if (!sys_reset_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (enable) w_next = SEND;
      SEND:    if (w_last_hs) w_next = (IFG_CYCLES == 0) ? IDLE : IFG;
      IFG:     if (r_ifg_cnt == IFG_LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Frame parameters, beat position, gap counter and frame counter
  always_ff @(posedge sysclk_100m) begin
    if (!sys_reset_n) begin
      r_beat        <= '0;
      r_last_beat   <= '0;
      r_ifg_cnt     <= '0;
      r_len         <= '0;
      r_dst         <= '0;
      r_src         <= '0;
      r_seq         <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_start) begin
        r_len       <= w_len;
        r_last_beat <= 8'((w_len - 11'd1) >> 3);
        r_dst       <= dst_mac;
        r_src       <= src_mac;
        r_seq       <= r_frame_count;
        r_beat      <= '0;
      end else if (w_hs) begin
        r_beat <= r_beat + 8'd1;
      end

      if (w_last_hs) r_frame_count <= r_frame_count + 32'd1;

      if (r_state == IFG) r_ifg_cnt <= r_ifg_cnt + 8'd1;
      else                r_ifg_cnt <= '0;
    end
  end

  // Output logic: beat contents are a pure function of registered state, so
  // they hold while stalled and never depend on tready.
  always_comb begin
    w_tvalid = (r_state == SEND);
    w_tlast  = w_tvalid && (r_beat == r_last_beat);
    w_tdata  = '0;
    w_tkeep  = '0;
    if (w_tvalid) begin
      for (int unsigned l = 0; l < 8; l++) begin
        if (({r_beat, 3'b000} | 11'(l)) < r_len) begin
          w_tkeep[l]       = 1'b1;
          w_tdata[8*l +: 8] = frame_byte({r_beat, 3'b000} | 11'(l),
                                         r_dst, r_src, ETH_TYPE, r_seq);
        end
      end
    end
  end

  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tlast  = w_tlast;
  assign m_axis_tdata  = w_tdata;
  assign m_axis_tkeep  = w_tkeep;
  assign frame_count   = r_frame_count;
  assign busy          = r_busy;

endmodule

// File: tb/tb_eth10g_frame_gen.sv
// Self-checking bench for eth10g_frame_gen: a frame-level reference model
// predicts every output each cycle; literal expectations pin the model.
module tb_eth10g_frame_gen;

  localparam int unsigned IFG = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        tready = 1'b0;
  logic [10:0] frame_len = 11'd60;
  logic [47:0] dst = '0;
  logic [47:0] src = '0;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic [31:0] fcount;
  logic        busy;

  always #5 clk = ~clk;

  eth10g_frame_gen #(.IFG_CYCLES(IFG), .ETH_TYPE(16'h88B5)) dut (
    .sysclk_100m  (clk),
    .sys_reset_n  (rst_n),
    .enable       (enable),
    .frame_len    (frame_len),
    .dst_mac      (dst),
    .src_mac      (src),
    .m_axis_tdata (tdata),
    .m_axis_tkeep (tkeep),
    .m_axis_tvalid(tvalid),
    .m_axis_tlast (tlast),
    .m_axis_tready(tready),
    .frame_count  (fcount),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic        m_on = 1'b0;
  logic        m_active = 1'b0;
  int          m_beat = 0;
  int          m_nbeats = 0;
  int          m_len = 0;
  int          m_cool = 0;
  logic [31:0] m_count = '0;
  logic [7:0]  m_bytes [0:2047];

  function automatic int clampf(input int len);
    if (len < 60) return 60;
    if (len > 1514) return 1514;
    return len;
  endfunction

  function automatic logic [7:0] exp_byte(input int n, input logic [47:0] d,
                                          input logic [47:0] s, input logic [31:0] q);
    if (n < 6)  return 8'(d >> (40 - 8*n));
    if (n < 12) return 8'(s >> (40 - 8*(n-6)));
    if (n == 12) return 8'h88;
    if (n == 13) return 8'hB5;
    if (n < 18) return 8'(q >> (24 - 8*(n-14)));
    return 8'(n % 256);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on = 1'b1; m_active = 1'b0; m_cool = 0; m_count = '0; m_beat = 0;
    end else if (m_on) begin
      if (m_active) begin
        if (tready) begin
          if (m_beat == m_nbeats - 1) begin
            m_active = 1'b0; m_count = m_count + 1; m_cool = IFG;
          end else m_beat++;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (enable) begin
        m_len = clampf(int'(frame_len));
        m_nbeats = (m_len + 7) / 8;
        for (int n = 0; n < m_len; n++) m_bytes[n] = exp_byte(n, dst, src, m_count);
        m_beat = 0;
        m_active = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare + monitor ----------------
  logic [63:0] q_b0[$];
  logic [63:0] q_last_d[$];
  logic [7:0]  q_last_k[$];
  int          q_nb[$];
  logic [31:0] q_seq[$];
  int          q_gap[$];
  int          mon_beat = 0;
  int          gap_run = 0;
  logic        in_gap = 1'b0;
  logic [63:0] cur_b0, cur_b1;
  logic [63:0] e_d;
  logic [7:0]  e_k;

  always @(negedge clk) begin
    if (m_on) begin
      chk("tvalid", 64'(tvalid), 64'(m_active));
      chk("frame_count", 64'(fcount), 64'(m_count));
      chk("busy", 64'(busy), 64'(m_active || m_cool > 0));
      if (m_active) begin
        e_d = '0; e_k = '0;
        for (int l = 0; l < 8; l++) begin
          if (m_beat*8 + l < m_len) begin
            e_k[l] = 1'b1;
            e_d[8*l +: 8] = m_bytes[m_beat*8 + l];
          end
        end
        chk("tdata", tdata, e_d);
        chk("tkeep", 64'(tkeep), 64'(e_k));
        chk("tlast", 64'(tlast), 64'(m_beat == m_nbeats - 1));
      end else begin
        chk("tlast_idle", 64'(tlast), 64'd0);
      end
    end
    if (!rst_n) begin
      mon_beat = 0; in_gap = 1'b0;
    end else begin
      if (!tvalid && in_gap) gap_run++;
      if (tvalid && in_gap) begin q_gap.push_back(gap_run); in_gap = 1'b0; end
      if (tvalid && tready) begin
        if (mon_beat == 0) cur_b0 = tdata;
        if (mon_beat == 1) cur_b1 = tdata;
        if (mon_beat == 2) q_seq.push_back({cur_b1[55:48], cur_b1[63:56], tdata[7:0], tdata[15:8]});
        mon_beat++;
        if (tlast) begin
          q_b0.push_back(cur_b0); q_last_d.push_back(tdata); q_last_k.push_back(tkeep);
          q_nb.push_back(mon_beat); mon_beat = 0; in_gap = 1'b1; gap_run = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic rand_mode = 1'b0;

  task automatic step();
    @(posedge clk); #1;
    if (rand_mode) begin
      tready = ($urandom_range(0, 3) != 0);
      dst = {16'($urandom), 32'($urandom)};
      src = {16'($urandom), 32'($urandom)};
    end
  endtask

  task automatic clear_q();
    q_b0.delete(); q_last_d.delete(); q_last_k.delete();
    q_nb.delete(); q_seq.delete(); q_gap.delete();
  endtask

  task automatic wait_frames(input int n);
    int budget = 3000;
    while (q_nb.size() < n && budget > 0) begin step(); budget--; end
    if (budget == 0) chk("timeout_frames", 64'(q_nb.size()), 64'(n));
  endtask

  task automatic start_one();
    int budget = 100;
    enable = 1'b1;
    while (!m_active && budget > 0) begin step(); budget--; end
    if (budget == 0) chk("timeout_start", 64'(m_active), 64'd1);
    enable = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 3000;
    while ((m_active || m_cool > 0) && budget > 0) begin step(); budget--; end
    if (budget == 0) chk("timeout_idle", 64'(m_active), 64'd0);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; step(); step(); rst_n = 1'b1; step();
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_tkeep", 64'(tkeep), 64'd0);
    chk("rst_count", 64'(fcount), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // 60-byte frame with known addresses
    dst = 48'h0A0B0C0D0E0F; src = 48'h001122334455; frame_len = 11'd60; tready = 1'b1;
    clear_q(); start_one(); wait_frames(1); wait_idle();
    chk("f60_beat0", q_b0[0], 64'h11000F0E0D0C0B0A);
    chk("f60_last", q_last_d[0], 64'h000000003B3A3938);
    chk("f60_keep", 64'(q_last_k[0]), 64'h0F);
    chk("f60_beats", 64'(q_nb[0]), 64'd8);
    chk("f60_seq", 64'(q_seq[0]), 64'd0);
    chk("f60_count", 64'(fcount), 64'd1);

    // maximum frame
    frame_len = 11'd1514;
    clear_q(); start_one(); wait_frames(1); wait_idle();
    chk("f1514_beats", 64'(q_nb[0]), 64'd190);
    chk("f1514_keep", 64'(q_last_k[0]), 64'h03);
    chk("f1514_last", q_last_d[0], 64'h000000000000E9E8);

    // clamping with random stalls and inputs changing mid-frame
    frame_len = 11'd20; rand_mode = 1'b1;
    clear_q(); start_one(); frame_len = 11'd2000; wait_frames(1);
    start_one(); wait_frames(2); wait_idle();
    rand_mode = 1'b0; tready = 1'b1;
    chk("clamp_lo_beats", 64'(q_nb[0]), 64'd8);
    chk("clamp_hi_beats", 64'(q_nb[1]), 64'd190);
    chk("clamp_hi_keep", 64'(q_last_k[1]), 64'h03);

    // continuous enable: gaps and sequence numbers
    do_reset();
    frame_len = 11'd64;
    clear_q(); enable = 1'b1; wait_frames(3); enable = 1'b0; wait_idle();
    chk("gap0", 64'(q_gap[0]), 64'(IFG + 1));
    chk("gap1", 64'(q_gap[1]), 64'(IFG + 1));
    chk("seq0", 64'(q_seq[0]), 64'd0);
    chk("seq1", 64'(q_seq[1]), 64'd1);
    chk("seq2", 64'(q_seq[2]), 64'd2);
    chk("f64_keep", 64'(q_last_k[0]), 64'hFF);

    // enable dropped mid-frame, then reset mid-frame
    clear_q(); enable = 1'b1;
    begin
      int budget = 200;
      while (!(m_active && m_beat == 3) && budget > 0) begin step(); budget--; end
      if (budget == 0) chk("timeout_beat3", 64'(m_beat), 64'd3);
    end
    enable = 1'b0;
    wait_frames(1);
    repeat (20) step();
    chk("no_new_frame", 64'(q_nb.size()), 64'd1);
    chk("drop_beats", 64'(q_nb[0]), 64'd8);
    enable = 1'b1;
    begin
      int budget = 200;
      while (!(m_active && m_beat == 5) && budget > 0) begin step(); budget--; end
      if (budget == 0) chk("timeout_beat5", 64'(m_beat), 64'd5);
    end
    enable = 1'b0;
    chk("pre_rst_count", 64'(fcount), 64'd4);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tvalid", 64'(tvalid), 64'd0);
    chk("post_rst_count", 64'(fcount), 64'd0);
    chk("trunc_not_counted", 64'(q_nb.size()), 64'd1);
    step(); wait_idle();

    // frame counter / sequence wrap
    @(negedge clk);
    dut.r_frame_count = 32'hFFFFFFFE;
    m_count = 32'hFFFFFFFE;
    clear_q(); step(); enable = 1'b1; wait_frames(3); enable = 1'b0; wait_idle();
    chk("wrap_seq0", 64'(q_seq[0]), 64'hFFFFFFFE);
    chk("wrap_seq1", 64'(q_seq[1]), 64'hFFFFFFFF);
    chk("wrap_seq2", 64'(q_seq[2]), 64'h00000000);
    chk("wrap_count", 64'(fcount), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
